// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes, protection default and command-master state encoding
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] PROT        = 3'b000;
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD, RD_R, RSP} state_t;
endpackage

// File: rtl/axil_wdog.sv
// axil_wdog: saturating watchdog that flags expiry after P_LIMIT enabled cycles since the last clear
module axil_wdog #(
  parameter int P_LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);
  localparam int W = $clog2(P_LIMIT);
  logic [W-1:0] r_cnt;
  assign o_expire = i_en && (r_cnt == W'(P_LIMIT - 1));
  always_ff @(posedge clk) begin
    if (rst || i_clear) r_cnt <= '0;
    else if (i_en && !o_expire) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding cmd/rsp to AXI4-Lite master; watchdog under AXIL_CMD_MASTER_TIMEOUT_EN
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int P_ADDR_WIDTH     = 8,
  parameter int P_DATA_WIDTH     = 32,
  parameter int P_TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [P_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [P_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [P_DATA_WIDTH-1:0]   m_wdata,
  output logic [P_DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [P_ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]                m_arprot,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [P_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                m_rresp,
  output logic                      busy
);
  if (P_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("P_TIMEOUT_CYCLES must be at least 2");
  end
  state_t                    r_state, w_next_raw, w_next;
  logic                      r_aw_done, r_w_done, r_write;
  logic [P_ADDR_WIDTH-1:0]   r_addr;
  logic [P_DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic [P_DATA_WIDTH/8-1:0] r_wstrb;
  logic [1:0]                r_resp;
  logic                      w_aw_fin, w_w_fin, w_timeout;
  // AW and W complete independently; the flags let them land in either order
  assign w_aw_fin = r_aw_done | m_awready;
  assign w_w_fin  = r_w_done | m_wready;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  logic w_expire;
  axil_wdog #(.P_LIMIT(P_TIMEOUT_CYCLES)) u_wdog (
    .clk      (ACLK),
    .rst      (ARESET),
    .i_clear  (r_state == IDLE),
    .i_en     (r_state != IDLE && r_state != RSP),
    .o_expire (w_expire)
  );
  // a handshake completing on the expiry cycle still wins over the watchdog
  assign w_timeout = w_expire && (w_next_raw == r_state);
`else
  assign w_timeout = 1'b0;
`endif
  always_ff @(posedge ACLK) r_state <= ARESET ? IDLE : w_next;
  always_comb begin
    w_next_raw = r_state;
    case (r_state)
      IDLE:    w_next_raw = cmd_valid ? (cmd_write ? WR : RD) : IDLE;
      WR:      w_next_raw = (w_aw_fin && w_w_fin) ? WR_B : WR;
      WR_B:    w_next_raw = m_bvalid ? RSP : WR_B;
      RD:      w_next_raw = m_arready ? RD_R : RD;
      RD_R:    w_next_raw = m_rvalid ? RSP : RD_R;
      RSP:     w_next_raw = rsp_ready ? IDLE : RSP;
      default: w_next_raw = IDLE;
    endcase
  end
  assign w_next = w_timeout ? RSP : w_next_raw;
  always_comb begin
    cmd_ready = r_state == IDLE;
    busy      = r_state != IDLE;
    m_awvalid = r_state == WR && !r_aw_done;
    m_wvalid  = r_state == WR && !r_w_done;
    m_bready  = r_state == WR_B;
    m_arvalid = r_state == RD;
    m_rready  = r_state == RD_R;
    rsp_valid = r_state == RSP;
  end
  assign m_awaddr  = r_addr;
  assign m_araddr  = r_addr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_awprot  = PROT;
  assign m_arprot  = PROT;
  assign rsp_write = r_write;
  assign rsp_rdata = r_rdata;
  assign rsp_resp  = r_resp;
  always_ff @(posedge ACLK) begin
    if (ARESET || (r_state == RSP && rsp_ready)) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
    end else if (r_state == IDLE) begin
      if (cmd_valid) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_wstrb <= cmd_wstrb;
      end
    end else begin
      r_aw_done <= r_aw_done | (r_state == WR && m_awready);
      r_w_done  <= r_w_done | (r_state == WR && m_wready);
      if (w_timeout) begin
        r_resp  <= RESP_DECERR;
        r_rdata <= '0;
      end else if (r_state == WR_B && m_bvalid) begin
        r_resp  <= m_bresp;
        r_rdata <= '0;
      end else if (r_state == RD_R && m_rvalid) begin
        r_resp  <= m_rresp;
        r_rdata <= m_rdata;
      end
    end
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: random and directed traffic against a word-memory reference model and AXI-Lite slave
module tb_axil_cmd_master;
  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0]  cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_awvalid, m_awready = 0, m_wvalid, m_wready = 0;
  logic [7:0]  m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [31:0] m_wdata, m_rdata = 0;
  logic [3:0]  m_wstrb;
  logic        m_bvalid = 0, m_bready, m_arvalid, m_arready = 0, m_rvalid = 0, m_rready, busy;
  logic [1:0]  m_bresp = 0, m_rresp = 0;
  int n_vec = 0, n_err = 0;
  always #5 ACLK = ~ACLK;
  axil_cmd_master #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32), .P_TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i+:8] = d[8*i+:8];
    return r;
  endfunction
  // slave: 0 random ready, 1 always ready, 2 AW held 3 cycles, 3 AR never, 4 B never
  logic [31:0] s_mem [256];
  logic [31:0] ref_mem [256];
  int s_mode = 1, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, aw_wait = 0;
  bit s_rst = 1, aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
  logic [7:0] aw_a = 0, ar_a = 0;
  logic [31:0] w_d = 0;
  logic [3:0] w_s = 0;
  function automatic bit rnd();
    return s_mode == 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction
  initial begin
    for (int i = 0; i < 256; i++) begin s_mem[i] = 0; ref_mem[i] = 0; end
    forever begin
      @(negedge ACLK);
      if (s_rst) begin
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; aw_wait = 0;
      end else begin
        if (b_fire) m_bvalid = 0;
        if (r_fire) m_rvalid = 0;
        if (aw_got && w_got && !m_bvalid && s_mode != 4 && rnd()) begin
          if (aw_a < 8'hC0) s_mem[aw_a] = merge(s_mem[aw_a], w_d, w_s);
          m_bresp = aw_a >= 8'hC0 ? 2'b10 : 2'b00;
          m_bvalid = 1; aw_got = 0; w_got = 0;
        end
        if (ar_got && !m_rvalid && rnd()) begin
          m_rdata = ar_a >= 8'hC0 ? 32'hDEAD_BEEF : s_mem[ar_a];
          m_rresp = ar_a >= 8'hC0 ? 2'b10 : 2'b00;
          m_rvalid = 1; ar_got = 0;
        end
        b_fire = m_bvalid && m_bready;
        r_fire = m_rvalid && m_rready;
        m_awready = s_mode == 2 ? (aw_wait >= 3) : rnd();
        if (m_awvalid) aw_wait++;
        if (m_awvalid && m_awready) begin aw_got = 1; aw_a = m_awaddr; aw_cnt++; aw_wait = 0; end
        m_wready = rnd();
        if (m_wvalid && m_wready) begin w_got = 1; w_d = m_wdata; w_s = m_wstrb; w_cnt++; end
        m_arready = s_mode == 3 ? 1'b0 : rnd();
        if (m_arvalid && m_arready) begin ar_got = 1; ar_a = m_araddr; ar_cnt++; end
      end
    end
  end
  task automatic set_mode(input int m);
    s_mode = m;
    @(negedge ACLK);
  endtask
  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
    chk("rsp_wait", rsp_valid, 1);
  endtask
  task automatic consume();
    rsp_ready = 1;
    @(negedge ACLK);
    rsp_ready = 0;
  endtask
  task automatic drive(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
  endtask
  task automatic do_cmd(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    int n = 0, aw0 = aw_cnt, w0 = w_cnt, ar0 = ar_cnt;
    bit err = a >= 8'hC0;
    logic [31:0] exp_d = w ? 32'h0 : (err ? 32'hDEAD_BEEF : ref_mem[a]);
    if (w && !err) ref_mem[a] = merge(ref_mem[a], d, s);
    drive(w, a, d, s);
    while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
    chk("cmd_accept", cmd_ready, 1);
    @(negedge ACLK);
    cmd_valid = 0;
    wait_rsp();
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_write", rsp_write, w);
      chk("rsp_rdata", rsp_rdata, exp_d);
      chk("rsp_resp", rsp_resp, err ? 2'b10 : 2'b00);
      if (i < hold) @(negedge ACLK);
    end
    consume();
    chk("rsp_drop", rsp_valid, 0);
    chk("aw_count", aw_cnt - aw0, w);
    chk("w_count", w_cnt - w0, w);
    chk("ar_count", ar_cnt - ar0, !w);
    if (w) chk("awaddr", aw_a, a);
    else chk("araddr", ar_a, a);
  endtask
  initial begin
    int n;
    logic [7:0] a;
    repeat (5) @(negedge ACLK);
    ARESET = 0; s_rst = 0;
    @(negedge ACLK);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 0);
    chk("rst_data", {m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 0);
    do_cmd(1, 8'h00, 32'h0000_0001, 4'hF, 0);
    do_cmd(0, 8'h00, 32'h0, 4'h0, 0);
    // zero-wait slave: fixed 3-cycle command-to-response latency
    ref_mem[4] = 32'hA5A5_0F0F;
    drive(1, 8'h04, 32'hA5A5_0F0F, 4'hF);
    @(negedge ACLK); cmd_valid = 0;
    chk("lat_wr_c1", {m_awvalid, m_wvalid, cmd_ready, busy}, 4'b1101);
    @(negedge ACLK); chk("lat_wr_c2", {m_bready, m_awvalid, m_wvalid}, 3'b100);
    @(negedge ACLK); chk("lat_wr_c3", {rsp_valid, rsp_resp}, 3'b100);
    consume();
    drive(0, 8'h04, 32'h0, 4'h0);
    @(negedge ACLK); cmd_valid = 0;
    chk("lat_rd_c1", m_arvalid, 1);
    @(negedge ACLK); chk("lat_rd_c2", {m_rready, m_arvalid}, 2'b10);
    @(negedge ACLK); chk("lat_rd_c3", rsp_valid, 1);
    chk("lat_rd_data", rsp_rdata, ref_mem[4]);
    consume();
    // W accepted three cycles ahead of AW
    set_mode(2);
    n = aw_cnt;
    ref_mem[8] = merge(ref_mem[8], 32'h1234_5678, 4'b0011);
    drive(1, 8'h08, 32'h1234_5678, 4'b0011);
    @(negedge ACLK); cmd_valid = 0;
    @(negedge ACLK);
    chk("wfirst_valids", {m_awvalid, m_wvalid}, 2'b10);
    chk("wfirst_aw_pending", aw_cnt - n, 0);
    wait_rsp();
    chk("wfirst_resp", rsp_resp, 0);
    consume();
    chk("wfirst_aw_once", aw_cnt - n, 1);
    repeat (3) @(negedge ACLK);
    chk("wfirst_single_rsp", rsp_valid, 0);
    do_cmd(0, 8'h08, 32'h0, 4'h0, 0);
    // stalled response with the next command already waiting
    set_mode(1);
    ref_mem[16] = 32'hCAFE_0010;
    drive(1, 8'h10, 32'hCAFE_0010, 4'hF);
    @(negedge ACLK); cmd_write = 0;
    wait_rsp();
    for (int i = 0; i < 4; i++) begin
      chk("hold_fields", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b00, 32'h0});
      chk("hold_cmd_ready", cmd_ready, 0);
      @(negedge ACLK);
    end
    consume();
    chk("hold_idle", {cmd_ready, busy}, 2'b10);
    @(negedge ACLK); cmd_valid = 0;
    chk("hold_accept", {busy, m_arvalid}, 2'b11);
    wait_rsp();
    chk("hold_rdata", rsp_rdata, 32'hCAFE_0010);
    consume();
    // reset while waiting for B
    set_mode(4);
    drive(1, 8'h0C, 32'h0BAD_0BAD, 4'hF);
    @(negedge ACLK); cmd_valid = 0;
    n = 0;
    while (!m_bready && n < 50) begin @(negedge ACLK); n++; end
    chk("rst_mid_wrb", m_bready, 1);
    ARESET = 1; s_rst = 1;
    @(negedge ACLK);
    chk("rst_mid_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, busy}, 0);
    ARESET = 0;
    @(negedge ACLK);
    s_rst = 0;
    chk("rst_mid_no_rsp", rsp_valid, 0);
    set_mode(0);
    do_cmd(1, 8'h0C, 32'h0000_C0DE, 4'hF, 1);
    do_cmd(0, 8'h0C, 32'h0, 4'h0, 0);
    // random traffic, including slave error region at 0xC0 and above
    for (int k = 0; k < 60; k++) begin
      a = 8'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) a = a | 8'hC0;
      do_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    set_mode(3);
    drive(0, 8'h20, 32'h0, 4'h0);
    @(negedge ACLK); cmd_valid = 0;
    n = 0;
    while (m_arvalid && n < 100) begin n++; @(negedge ACLK); end
    chk("to_arvalid_cycles", n, 16);
    chk("to_rsp", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b11, 32'h0});
    chk("to_ready_low", {m_arvalid, m_rready}, 2'b00);
    consume();
    s_rst = 1;
    repeat (2) @(negedge ACLK);
    s_rst = 0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Upstream driver for the base register block.
- Converts a simple single-beat command/response interface into AXI4-Lite master transactions on the base slave port (AW/W/B/AR/R).
- One transaction outstanding at a time.
- Replaces bench-only write tasks so that on-chip sequencers (boot init, self-test) can program base registers.

Parameters:
- P_ADDR_WIDTH, 8: AXI address width; matches base.
- P_DATA_WIDTH, 32: AXI data width; strobe width is P_DATA_WIDTH/8.
- P_TIMEOUT_CYCLES, 256: watchdog limit, used only with the optional feature.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  P_ADDR_WIDTH  address
- cmd_wdata  in  P_DATA_WIDTH  write data
- cmd_wstrb  in  P_DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  P_DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  AXI response code
- m_awvalid/m_awready  out/in  1  AW handshake
- m_awaddr  out  P_ADDR_WIDTH
- m_awprot  out  3  constant 3'b000
- m_wvalid/m_wready  out/in  1
- m_wdata  out  P_DATA_WIDTH
- m_wstrb  out  P_DATA_WIDTH/8
- m_bvalid/m_bready  in/out  1
- m_bresp  in  2
- m_arvalid/m_arready  out/in  1
- m_araddr  out  P_ADDR_WIDTH
- m_arprot  out  3  constant 3'b000
- m_rvalid/m_rready  in/out  1
- m_rdata  in  P_DATA_WIDTH
- m_rresp  in  2
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all m_*valid, m_*ready and rsp_valid are 0. cmd_ready is 1 in IDLE from the first edge after reset release. All address/data/resp outputs are 0. busy is 0.
- Reset mid-transaction: the next ACLK edge forces IDLE and drops every valid/ready; no response is issued.
- State machine:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/wdata/wstrb/write; go to WR (write) or RD (read).
  - WR: m_awvalid and m_wvalid are registered high. Each is held until its own handshake; aw_done/w_done flags allow either order or the same cycle. When both are done, go to WR_B.
  - WR_B: m_bready=1. On m_bvalid, capture m_bresp, clear rsp_rdata, go to RSP.
  - RD: m_arvalid=1 until m_arready, then go to RD_R.
  - RD_R: m_rready=1. On m_rvalid, capture m_rdata/m_rresp, go to RSP.
  - RSP: rsp_valid=1 with stable fields until rsp_ready, then go to IDLE.
- Outputs m_*addr/data/strb are stable while the corresponding valid is high. They are cleared to 0 on returning to IDLE.
- Latency with an always-ready slave:
  - Write: cmd accept at cycle 0, AW/W valid at cycle 1, bready at cycle 2, rsp_valid at cycle 3 if bvalid arrives at cycle 2.
  - Read: arvalid at 1, rready at 2, rsp_valid at 3.
- Throughput: one command per 4 cycles minimum. cmd_ready is low outside IDLE, so back-to-back commands stall.
- m_bvalid/m_rvalid are ignored outside WR_B/RD_R (ready is low there).
- A response error (resp != 2'b00) is passed through unchanged; no retry.

Optional Feature:
- Macro: AXIL_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entering WR/RD and counts every cycle in WR, WR_B, RD and RD_R.
  - When the count reaches P_TIMEOUT_CYCLES-1, all m_* valid/ready signals drop on the next edge.
  - The FSM then goes to RSP with rsp_resp=2'b11 and rsp_rdata=0.
  - A subsequent command is legal, but the slave requires reset.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Package axil_pkg:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - state encoding typedef (IDLE, WR, WR_B, RD, RD_R, RSP);
  - default PROT=3'b000.
- Sub-module: none for the core FSM. The optional watchdog is a natural small sub-module, axil_wdog (clear, enable, expire), instantiated only under the macro.

Test Plan:
- Reset held 5 cycles, then released -> all valids 0 and cmd_ready=1 at the first post-reset edge; busy=0.
- Write addr 8'h00, data 32'h0000_0001, strb 4'hF to base; readback of addr 8'h00 -> rsp_resp=2'b00, then rsp_rdata=32'h0000_0001; LEDs reflect the value per the base register map.
- Slave asserts wready 3 cycles before awready -> exactly one W and one AW handshake; m_wvalid low after its handshake while m_awvalid is still held; single response.
- rsp_ready held low 4 cycles in RSP -> rsp_valid and fields stable; cmd_valid held high is not accepted until 1 cycle after rsp_ready.
- ARESET asserted in WR_B -> next edge all m_* valid/ready 0, no rsp_valid; a new write after reset completes normally.
- With AXIL_CMD_MASTER_TIMEOUT_EN and P_TIMEOUT_CYCLES=16, slave never asserts arready -> m_arvalid drops after 16 cycles; rsp_valid with rsp_resp=2'b11, rsp_rdata=0.
